restore_state: RTL

- Reloads a suspended process's processor context from RAM, the inverse of the save-state stage.
- Walks a fixed 6-word context frame starting at a caller-supplied base address and issues synchronous reads to the single-port IceRam.
- Unpacks each returned word into the register values the core reloads: program counter, ALU flags, call-stack pointer, stack pointer and the three top-of-stack registers.
- Asserts finished when the whole frame has been captured; the scheduler then resumes the process.

---
 rtl/restore_state_pkg.sv | 27 ++
 rtl/restore_state.sv | 115 +++++++++++
 2 files changed

// File: rtl/restore_state_pkg.sv
// Context-frame layout shared by the save and restore stages, plus the restore FSM encoding.
package restore_state_pkg;

  localparam int ADDRESS_BITS = 8;
  localparam int DATA_BITS    = 16;
  localparam int STATE_WORDS  = 6;

  localparam logic [2:0] OFF_FLAGS_PC = 3'd0;
  localparam logic [2:0] OFF_CSP      = 3'd1;
  localparam logic [2:0] OFF_SP       = 3'd2;
  localparam logic [2:0] OFF_TOS1     = 3'd3;
  localparam logic [2:0] OFF_TOS2     = 3'd4;
  localparam logic [2:0] OFF_TOS3     = 3'd5;

  localparam int PC_LSB    = 0;
  localparam int PC_MSB    = 8;
  localparam int FLAGS_LSB = 9;
  localparam int FLAGS_MSB = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    LAST = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/restore_state.sv
// Reloads a 6-word processor context frame from single-port RAM and unpacks it
// into the PC, flags, stack pointers and top-of-stack cache.
module restore_state
  import restore_state_pkg::*;
#(
  parameter int addrBits = ADDRESS_BITS,
  parameter int dataBits = DATA_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [addrBits-1:0] stateAddress,
  input  logic [dataBits-1:0] dataOut,
  output logic [addrBits-1:0] address,
  output logic                rwMode,
  output logic [dataBits-1:0] dataIn,
  output logic                finished,
  output logic [8:0]          programCounter,
  output logic [3:0]          aluFlags,
  output logic [addrBits-1:0] callStackPointer,
  output logic [addrBits-1:0] stackPointer,
  output logic [dataBits-1:0] topOfStack1,
  output logic [dataBits-1:0] topOfStack2,
  output logic [dataBits-1:0] topOfStack3
);

  state_t              state, state_nxt;
  logic [addrBits-1:0] base;
  logic [2:0]          idx;
  logic                cap_en;
  logic [2:0]          cap_idx;
  logic                adv;
  logic [addrBits-1:0] addr_nxt;

  assign rwMode = 1'b0;
  assign dataIn = '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // RAM data lags the address by one edge, so the word captured is always idx-1.
  always_comb begin
    state_nxt = state;
    cap_en    = 1'b0;
    cap_idx   = idx - 3'd1;
    adv       = 1'b0;
    addr_nxt  = base + addrBits'(idx) + addrBits'(1);
    case (state)
      IDLE: if (start) state_nxt = READ;
      READ: begin
        if (!start) state_nxt = IDLE;
        else begin
          adv    = 1'b1;
          cap_en = (idx != 3'd0);
          if (idx == 3'd5) state_nxt = LAST;
        end
      end
      LAST: begin
        if (!start) state_nxt = IDLE;
        else begin
          cap_en    = 1'b1;
          cap_idx   = OFF_TOS3;
          state_nxt = DONE;
        end
      end
      DONE: if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base             <= '0;
      idx              <= '0;
      address          <= '0;
      finished         <= 1'b0;
      programCounter   <= '0;
      aluFlags         <= '0;
      callStackPointer <= '0;
      stackPointer     <= '0;
      topOfStack1      <= '0;
      topOfStack2      <= '0;
      topOfStack3      <= '0;
    end else begin
      finished <= (state_nxt == DONE);
      if (state == IDLE && start) begin
        base    <= stateAddress;
        address <= stateAddress;
        idx     <= '0;
      end
      if (adv) begin
        idx <= idx + 3'd1;
        // Last frame address already issued once idx hits 5; hold it there.
        if (idx != 3'd5) address <= addr_nxt;
      end
      if (cap_en) begin
        case (cap_idx)
          OFF_FLAGS_PC: begin
            programCounter <= dataOut[PC_MSB:PC_LSB];
            aluFlags       <= dataOut[FLAGS_MSB:FLAGS_LSB];
          end
          OFF_CSP:  callStackPointer <= dataOut[addrBits-1:0];
          OFF_SP:   stackPointer     <= dataOut[addrBits-1:0];
          OFF_TOS1: topOfStack1      <= dataOut;
          OFF_TOS2: topOfStack2      <= dataOut;
          OFF_TOS3: topOfStack3      <= dataOut;
          default: ;
        endcase
      end
    end
  end

endmodule
